// File: rtl/coeff_token_enc_pipe.sv
// Two-stage CAVLC coeff_token encoder: nC/table select, then ROM or FLC lookup.
// Define CHROMA_DC_EN to build in the chroma DC (nC = -1) table.
module coeff_token_enc_pipe #(
    parameter int NUM_WIDTH  = 5,
    parameter int CODE_WIDTH = 16,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [NUM_WIDTH-1:0]  total_coeff,
    input  logic [1:0]            trailing_ones,
    input  logic [NUM_WIDTH-1:0]  n_a,
    input  logic [NUM_WIDTH-1:0]  n_b,
    input  logic                  avail_a,
    input  logic                  avail_b,
    input  logic                  chroma_dc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CODE_WIDTH-1:0] code_val,
    output logic [LEN_WIDTH-1:0]  code_len,
    output logic                  err
);

    typedef enum logic [2:0] {
        SEL_T0  = 3'd0,
        SEL_T1  = 3'd1,
        SEL_T2  = 3'd2,
        SEL_FLC = 3'd3,
        SEL_CDC = 3'd4
    } tab_sel_t;

    // Each row packs the four TrailingOnes entries {t1=3, t1=2, t1=1, t1=0}, entry = {len-1, value}.
    function automatic logic [31:0] t0_row(input logic [4:0] tc);
        case (tc)
            5'd0:    t0_row = 32'h00000001;
            5'd1:    t0_row = 32'h00001155;
            5'd2:    t0_row = 32'h00215477;
            5'd3:    t0_row = 32'h43657687;
            5'd4:    t0_row = 32'h53758697;
            5'd5:    t0_row = 32'h648596A7;
            5'd6:    t0_row = 32'h7495A6CF;
            5'd7:    t0_row = 32'h84A5CECB;
            5'd8:    t0_row = 32'h94CDCAC8;
            5'd9:    t0_row = 32'hA4C9DEDF;
            5'd10:   t0_row = 32'hCCDDDADB;
            5'd11:   t0_row = 32'hDCD9EEEF;
            5'd12:   t0_row = 32'hD8EDEAEB;
            5'd13:   t0_row = 32'hECE9E1FF;
            5'd14:   t0_row = 32'hE8FDFEFB;
            5'd15:   t0_row = 32'hFCF9FAF7;
            5'd16:   t0_row = 32'hF8F5F6F4;
            default: t0_row = 32'h00000000;
        endcase
    endfunction

    function automatic logic [31:0] t1_row(input logic [4:0] tc);
        case (tc)
            5'd0:    t1_row = 32'h00000013;
            5'd1:    t1_row = 32'h0000125B;
            5'd2:    t1_row = 32'h00234757;
            5'd3:    t1_row = 32'h35595A67;
            5'd4:    t1_row = 32'h34555677;
            5'd5:    t1_row = 32'h46656674;
            5'd6:    t1_row = 32'h58757687;
            5'd7:    t1_row = 32'h548586AF;
            5'd8:    t1_row = 32'h64ADAEAB;
            5'd9:    t1_row = 32'h84A9AABF;
            5'd10:   t1_row = 32'hACBDBEBB;
            5'd11:   t1_row = 32'hA8B9BAB8;
            5'd12:   t1_row = 32'hBCCDCECF;
            5'd13:   t1_row = 32'hCCC9CACB;
            5'd14:   t1_row = 32'hC8C6DBC7;
            5'd15:   t1_row = 32'hC1DAD8D9;
            5'd16:   t1_row = 32'hD4D5D6D7;
            default: t1_row = 32'h00000000;
        endcase
    endfunction

    function automatic logic [31:0] t2_row(input logic [4:0] tc);
        case (tc)
            5'd0:    t2_row = 32'h0000003F;
            5'd1:    t2_row = 32'h00003E5F;
            5'd2:    t2_row = 32'h003D4F5B;
            5'd3:    t2_row = 32'h3C4E4C58;
            5'd4:    t2_row = 32'h3B4B4A6F;
            5'd5:    t2_row = 32'h3A49486B;
            5'd6:    t2_row = 32'h395D5E69;
            5'd7:    t2_row = 32'h38595A68;
            5'd8:    t2_row = 32'h4D6D6E7F;
            5'd9:    t2_row = 32'h5C6A7E7B;
            5'd10:   t2_row = 32'h6C7D7A8F;
            5'd11:   t2_row = 32'h7C798E8B;
            5'd12:   t2_row = 32'h788D8A88;
            5'd13:   t2_row = 32'h8C89879D;
            5'd14:   t2_row = 32'h9A9B9C99;
            5'd15:   t2_row = 32'h96979895;
            5'd16:   t2_row = 32'h92939491;
            default: t2_row = 32'h00000000;
        endcase
    endfunction

`ifdef CHROMA_DC_EN
    function automatic logic [31:0] cdc_row(input logic [4:0] tc);
        case (tc)
            5'd0:    cdc_row = 32'h00000011;
            5'd1:    cdc_row = 32'h00000157;
            5'd2:    cdc_row = 32'h00215654;
            5'd3:    cdc_row = 32'h55626353;
            5'd4:    cdc_row = 32'h60727352;
            default: cdc_row = 32'h00000000;
        endcase
    endfunction
`endif

    logic                 adv1_s, adv2_s;
    logic [NUM_WIDTH:0]   nb_sum_s, nc_s;
    tab_sel_t             sel_s;
    logic                 pre_err_s;

    logic                 s1_valid_r;
    logic [NUM_WIDTH-1:0] s1_tc_r;
    logic [1:0]           s1_t1_r;
    tab_sel_t             s1_sel_r;
    logic                 s1_err_r;

    logic [31:0]          rom_row_s;
    logic [7:0]           rom_entry_s;
    logic                 rom_used_s, sel_bad_s;
    logic [3:0]           tc_m1_s;
    logic [CODE_WIDTH-1:0] lk_val_s;
    logic [LEN_WIDTH-1:0]  lk_len_s;
    logic                  lk_err_s;

    assign adv2_s   = !out_valid || out_ready;
    assign adv1_s   = !s1_valid_r || adv2_s;
    assign in_ready = adv1_s;

    // Extra sum bit keeps the rounding average exact at the top of the count range.
    assign nb_sum_s = {1'b0, n_a} + {1'b0, n_b} + (NUM_WIDTH+1)'(1'b1);
    assign tc_m1_s  = s1_tc_r[3:0] - 4'd1;

    // nC from neighbour availability, then Table 9-5 column select.
    always_comb begin
        nc_s      = {(NUM_WIDTH+1){1'b0}};
        sel_s     = SEL_T0;
        pre_err_s = (total_coeff > NUM_WIDTH'(5'd16)) ||
                    (NUM_WIDTH'(trailing_ones) > total_coeff);
        if (avail_a && avail_b) begin
            nc_s = nb_sum_s >> 1;
        end else if (avail_a) begin
            nc_s = {1'b0, n_a};
        end else if (avail_b) begin
            nc_s = {1'b0, n_b};
        end else begin
            nc_s = {(NUM_WIDTH+1){1'b0}};
        end
        if (chroma_dc) begin
            sel_s = SEL_CDC;
        end else if (nc_s < (NUM_WIDTH+1)'(4'd2)) begin
            sel_s = SEL_T0;
        end else if (nc_s < (NUM_WIDTH+1)'(4'd4)) begin
            sel_s = SEL_T1;
        end else if (nc_s < (NUM_WIDTH+1)'(4'd8)) begin
            sel_s = SEL_T2;
        end else begin
            sel_s = SEL_FLC;
        end
    end

    // Stage 1 request register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_tc_r    <= {NUM_WIDTH{1'b0}};
            s1_t1_r    <= 2'd0;
            s1_sel_r   <= SEL_T0;
            s1_err_r   <= 1'b0;
        end else if (adv1_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_tc_r  <= total_coeff;
                s1_t1_r  <= trailing_ones;
                s1_sel_r <= sel_s;
                s1_err_r <= pre_err_s;
            end
        end
    end

    // Stage 2 lookup; an all-zero ROM entry marks an undefined code.
    always_comb begin
        rom_row_s   = 32'h00000000;
        rom_used_s  = 1'b0;
        sel_bad_s   = 1'b0;
        lk_val_s    = {CODE_WIDTH{1'b0}};
        lk_len_s    = {LEN_WIDTH{1'b0}};
        lk_err_s    = 1'b0;
        case (s1_sel_r)
            SEL_T0:  begin rom_row_s = t0_row(s1_tc_r[4:0]); rom_used_s = 1'b1; end
            SEL_T1:  begin rom_row_s = t1_row(s1_tc_r[4:0]); rom_used_s = 1'b1; end
            SEL_T2:  begin rom_row_s = t2_row(s1_tc_r[4:0]); rom_used_s = 1'b1; end
            SEL_FLC: rom_used_s = 1'b0;
`ifdef CHROMA_DC_EN
            SEL_CDC: begin rom_row_s = cdc_row(s1_tc_r[4:0]); rom_used_s = 1'b1; end
`else
            SEL_CDC: sel_bad_s = 1'b1;
`endif
            default: sel_bad_s = 1'b1;
        endcase
        rom_entry_s = rom_row_s[{s1_t1_r, 3'b000} +: 8];
        if (s1_err_r || sel_bad_s || (rom_used_s && (rom_entry_s == 8'h00))) begin
            lk_err_s = 1'b1;
        end else if (rom_used_s) begin
            lk_val_s = CODE_WIDTH'(rom_entry_s[3:0]);
            lk_len_s = LEN_WIDTH'(rom_entry_s[7:4]) + LEN_WIDTH'(1'b1);
        end else if (s1_tc_r == NUM_WIDTH'(1'b0)) begin
            lk_val_s = CODE_WIDTH'(6'b000011);
            lk_len_s = LEN_WIDTH'(3'd6);
        end else begin
            lk_val_s = CODE_WIDTH'({tc_m1_s, s1_t1_r});
            lk_len_s = LEN_WIDTH'(3'd6);
        end
    end

    // Output register; holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            code_val  <= {CODE_WIDTH{1'b0}};
            code_len  <= {LEN_WIDTH{1'b0}};
            err       <= 1'b0;
        end else if (adv2_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                code_val <= lk_val_s;
                code_len <= lk_len_s;
                err      <= lk_err_s;
            end
        end
    end

endmodule
